bram_write_arbiter: RTL and testbench

BRAM_WRITE_ARBITER -- requirements
Module: bram_write_arbiter

---
 rtl/bram_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_bram_write_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bram_write_arbiter.sv
// rtl/bram_write_arbiter.sv - two-requester round-robin burst arbiter driving one BRAM write port
module bram_write_arbiter #(
    parameter int BRAM_DEPTH = 16384,
    parameter int MAX_BURST  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] addr_bram,
    output logic [31:0] data2bram,
    output logic        memen,
    output logic [3:0]  web,
    output logic        err0,
    output logic        err1,
    output logic [31:0] cnt0,
    output logic [31:0] cnt1
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_G0      = 2'd1;
    localparam logic [1:0]  S_G1      = 2'd2;
    localparam logic [31:0] WORDS     = 32'(BRAM_DEPTH / 4);
    localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);

    logic [1:0]  state, state_nx;
    logic [7:0]  burst, burst_nx, burst_inc;
    logic        last_gnt;
    logic        acc0, acc1, beat_valid, beat_in_range;
    logic [31:0] beat_addr, beat_data;

    // rst_n is active-high despite its name
    assign gnt0 = (state == S_G0) && en;
    assign gnt1 = (state == S_G1) && en;
    assign acc0 = req0 && gnt0;
    assign acc1 = req1 && gnt1;

    assign beat_valid    = acc0 || acc1;
    assign beat_addr     = acc1 ? addr1 : addr0;
    assign beat_data     = acc1 ? data1 : data0;
    assign beat_in_range = beat_addr < WORDS;
    assign burst_inc     = burst + 8'd1;

    always_comb begin
        state_nx = state;
        burst_nx = burst;
        if (!en) begin
            state_nx = S_IDLE;
            burst_nx = 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    burst_nx = 8'd0;
                    if (req0 && req1)
                        state_nx = last_gnt ? S_G0 : S_G1;
                    else if (req0)
                        state_nx = S_G0;
                    else if (req1)
                        state_nx = S_G1;
                end
                S_G0: begin
                    if (!req0) begin
                        state_nx = req1 ? S_G1 : S_IDLE;
                        burst_nx = 8'd0;
                    end else if (burst_inc == BURST_MAX) begin
                        // burst limit only hands over when the other side is waiting
                        burst_nx = 8'd0;
                        if (req1)
                            state_nx = S_G1;
                    end else begin
                        burst_nx = burst_inc;
                    end
                end
                S_G1: begin
                    if (!req1) begin
                        state_nx = req0 ? S_G0 : S_IDLE;
                        burst_nx = 8'd0;
                    end else if (burst_inc == BURST_MAX) begin
                        burst_nx = 8'd0;
                        if (req0)
                            state_nx = S_G0;
                    end else begin
                        burst_nx = burst_inc;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    burst_nx = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= S_IDLE;
            burst    <= 8'd0;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nx;
            burst <= burst_nx;
            if (state == S_G0)
                last_gnt <= 1'b0;
            else if (state == S_G1)
                last_gnt <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            memen     <= 1'b0;
            web       <= 4'h0;
            addr_bram <= 32'd0;
            data2bram <= 32'd0;
        end else begin
            memen <= beat_valid && beat_in_range;
            web   <= {4{beat_valid && beat_in_range}};
            if (beat_valid) begin
                addr_bram <= {beat_addr[29:0], 2'b00};
                data2bram <= beat_data;
            end
        end
    end

    // clr wins over a same-cycle beat; the beat is still written to BRAM above
    always_ff @(posedge clk) begin
        if (rst_n || clr) begin
            err0 <= 1'b0;
            err1 <= 1'b0;
            cnt0 <= 32'd0;
            cnt1 <= 32'd0;
        end else begin
            if (acc0 && beat_in_range)
                cnt0 <= cnt0 + 32'd1;
            if (acc0 && !beat_in_range)
                err0 <= 1'b1;
            if (acc1 && beat_in_range)
                cnt1 <= cnt1 + 32'd1;
            if (acc1 && !beat_in_range)
                err1 <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bram_write_arbiter.sv
// tb/tb_bram_write_arbiter.sv - directed self-checking bench for bram_write_arbiter
module tb_bram_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [31:0] addr0 = 32'd0;
    logic [31:0] addr1 = 32'd0;
    logic [31:0] data0 = 32'd0;
    logic [31:0] data1 = 32'd0;
    logic        gnt0, gnt1, memen, err0, err1;
    logic [3:0]  web;
    logic [31:0] addr_bram, data2bram, cnt0, cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    bram_write_arbiter #(.BRAM_DEPTH(16384), .MAX_BURST(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
        .addr_bram(addr_bram), .data2bram(data2bram), .memen(memen), .web(web),
        .err0(err0), .err1(err1), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        step();
        step();
        n_cmp++; if ({gnt0, gnt1} !== 2'b00) begin n_bad++; $display("FAIL reset_gnt got %b exp 00", {gnt0, gnt1}); end
        n_cmp++; if (memen !== 1'b0 || web !== 4'h0) begin n_bad++; $display("FAIL reset_memen got %b/%h exp 0/0", memen, web); end
        n_cmp++; if (addr_bram !== 32'd0 || data2bram !== 32'd0) begin n_bad++; $display("FAIL reset_bus got %h/%h exp 0/0", addr_bram, data2bram); end
        n_cmp++; if ({err0, err1} !== 2'b00 || cnt0 !== 32'd0 || cnt1 !== 32'd0) begin n_bad++; $display("FAIL reset_stat got err %b cnt %0d/%0d exp 00 0/0", {err0, err1}, cnt0, cnt1); end
        rst_n = 1'b0;
    endtask

    task automatic test_single;
        en = 1'b1; req0 = 1'b1; addr0 = 32'd0; data0 = 32'hA;
        #1;
        n_cmp++; if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL single_nogrant_same_cycle got %b exp 0", gnt0); end
        step();
        n_cmp++; if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL single_grant got %b exp 1", gnt0); end
        for (int i = 0; i < 3; i++) begin
            addr0 = 32'(i); data0 = 32'hA + 32'(i);
            step();
            n_cmp++;
            if (memen !== 1'b1 || web !== 4'hF || addr_bram !== 32'(4 * i) || data2bram !== 32'hA + 32'(i)) begin
                n_bad++;
                $display("FAIL single_beat%0d got memen %b web %h addr %h data %h exp 1 F %h %h",
                         i, memen, web, addr_bram, data2bram, 4 * i, 32'hA + 32'(i));
            end
        end
        n_cmp++; if (cnt0 !== 32'd3) begin n_bad++; $display("FAIL single_cnt0 got %0d exp 3", cnt0); end
        req0 = 1'b0;
        step();
        n_cmp++; if (memen !== 1'b0 || web !== 4'h0 || addr_bram !== 32'd8) begin n_bad++; $display("FAIL single_idle got %b %h %h exp 0 0 8", memen, web, addr_bram); end
    endtask

    task automatic test_both;
        logic [7:0] exp_g1;
        exp_g1 = 8'b11001100;
        rst_n = 1'b1;
        step();
        rst_n = 1'b0; en = 1'b1;
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'd5; addr1 = 32'd6;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (gnt1 !== exp_g1[i] || gnt0 !== ~exp_g1[i]) begin
                n_bad++;
                $display("FAIL both_seq%0d got gnt0 %b gnt1 %b exp gnt1 %b", i, gnt0, gnt1, exp_g1[i]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
    endtask

    task automatic test_burst_continue;
        clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b1; req0 = 1'b1; addr0 = 32'd9; data0 = 32'h99;
        step();
        for (int i = 1; i <= 6; i++) begin
            step();
            n_cmp++;
            if (gnt0 !== 1'b1 || cnt0 !== 32'(i)) begin
                n_bad++;
                $display("FAIL burst_cont%0d got gnt0 %b cnt0 %0d exp 1 %0d", i, gnt0, cnt0, i);
            end
        end
        clr = 1'b1;
        step();
        n_cmp++; if (memen !== 1'b1 || cnt0 !== 32'd0) begin n_bad++; $display("FAIL clr_priority got memen %b cnt0 %0d exp 1 0", memen, cnt0); end
        clr = 1'b0; req0 = 1'b0;
        step();
    endtask

    task automatic test_out_of_range;
        clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b1; req1 = 1'b1; addr1 = 32'd4096; data1 = 32'h55;
        step();
        n_cmp++; if (gnt1 !== 1'b1) begin n_bad++; $display("FAIL oor_grant got %b exp 1", gnt1); end
        step();
        n_cmp++; if (memen !== 1'b0 || web !== 4'h0 || err1 !== 1'b1 || cnt1 !== 32'd0) begin n_bad++; $display("FAIL oor_beat got memen %b web %h err1 %b cnt1 %0d exp 0 0 1 0", memen, web, err1, cnt1); end
        addr1 = 32'd4095; data1 = 32'h66;
        step();
        n_cmp++; if (memen !== 1'b1 || addr_bram !== 32'h3FFC || cnt1 !== 32'd1 || err0 !== 1'b0) begin n_bad++; $display("FAIL top_word got memen %b addr %h cnt1 %0d err0 %b exp 1 3ffc 1 0", memen, addr_bram, cnt1, err0); end
        req1 = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        n_cmp++; if (err1 !== 1'b0 || cnt1 !== 32'd0) begin n_bad++; $display("FAIL oor_clr got err1 %b cnt1 %0d exp 0 0", err1, cnt1); end
    endtask

    task automatic test_en_drop;
        en = 1'b1; req0 = 1'b1; addr0 = 32'd3; data0 = 32'h33;
        step();
        step();
        n_cmp++; if (memen !== 1'b1 || gnt0 !== 1'b1) begin n_bad++; $display("FAIL en_pre got memen %b gnt0 %b exp 1 1", memen, gnt0); end
        en = 1'b0;
        #1;
        n_cmp++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_bad++; $display("FAIL en_drop_comb got %b%b exp 00", gnt0, gnt1); end
        step();
        n_cmp++; if (memen !== 1'b0) begin n_bad++; $display("FAIL en_drop_memen got %b exp 0", memen); end
        en = 1'b1;
        #1;
        n_cmp++; if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL en_idle got %b exp 0", gnt0); end
        step();
        n_cmp++; if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL en_regrant got %b exp 1", gnt0); end
        req0 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_burst;
        en = 1'b1; req1 = 1'b1; addr1 = 32'd7; data1 = 32'h77;
        step();
        step();
        n_cmp++; if (gnt1 !== 1'b1 || memen !== 1'b1) begin n_bad++; $display("FAIL rmb_pre got gnt1 %b memen %b exp 1 1", gnt1, memen); end
        rst_n = 1'b1; req0 = 1'b1;
        step();
        n_cmp++; if ({gnt0, gnt1} !== 2'b00 || memen !== 1'b0 || web !== 4'h0) begin n_bad++; $display("FAIL rmb_out got gnt %b%b memen %b web %h exp 00 0 0", gnt0, gnt1, memen, web); end
        n_cmp++; if (addr_bram !== 32'd0 || data2bram !== 32'd0 || cnt1 !== 32'd0) begin n_bad++; $display("FAIL rmb_regs got %h %h %0d exp 0 0 0", addr_bram, data2bram, cnt1); end
        rst_n = 1'b0;
        step();
        n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_bad++; $display("FAIL rmb_first_grant got gnt0 %b gnt1 %b exp 1 0", gnt0, gnt1); end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_burst_continue();
        test_out_of_range();
        test_en_drop();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    always @(negedge clk) begin
        if (gnt0 && gnt1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mutex got gnt0 %b gnt1 %b exp not both", gnt0, gnt1);
        end
    end

endmodule
